shift_sequencer_16b: RTL



---
 rtl/shift_sequencer_16b.sv | 118 +++++++++++
 1 files changed

// File: rtl/shift_sequencer_16b.sv
// Multi-cycle shift/rotate sequencer: one bit position per clock on a WIDTH-bit operand.
// Accepts start/op/data/amount in IDLE, returns result and carry_out with a one-cycle done pulse.
module shift_sequencer_16b #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  state_t                  state_p0;
  state_t                  state_nxt;
  logic signed [WIDTH-1:0] work_p0;
  logic [AMT_W-1:0]        cnt_p0;
  logic [1:0]              op_p0;
  logic [WIDTH:0]          step_p0;
  logic                    accept;
  logic                    last_shift;

  // Single-position step; returns {bit shifted/rotated out, new work value}.
  function automatic logic [WIDTH:0] shift_one(input logic [1:0] o,
                                               input logic signed [WIDTH-1:0] w);
    logic [WIDTH:0] r;
    case (o)
      OP_SLL:  r = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {w[0], 1'b0, w[WIDTH-1:1]};
      OP_SRA:  r = {w[0], w >>> 1};
      default: r = {w[WIDTH-1], w[WIDTH-2:0], w[WIDTH-1]};
    endcase
    return r;
  endfunction

  assign step_p0    = shift_one(op_p0, work_p0);
  assign accept     = (state_p0 == IDLE) && start;
  assign last_shift = (state_p0 == SHIFT) && (cnt_p0 == CNT_ONE);

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE: begin
        if (start) begin
          state_nxt = (amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_p0 == CNT_ONE) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: state plus registered busy/done decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
    end
  end

  // Datapath: work register and counter, iterated once per SHIFT cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      work_p0 <= '0;
      cnt_p0  <= '0;
      op_p0   <= '0;
    end else if (accept) begin
      work_p0 <= data_in;
      cnt_p0  <= amount;
      op_p0   <= op;
    end else if (state_p0 == SHIFT) begin
      work_p0 <= step_p0[WIDTH-1:0];
      cnt_p0  <= cnt_p0 - CNT_ONE;
    end
  end

  // Outputs change only on entry to DONE, so intermediate values never show
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      carry_out <= 1'b0;
    end else if (accept && (amount == '0)) begin
      result    <= data_in;
      carry_out <= 1'b0;
    end else if (last_shift) begin
      result    <= step_p0[WIDTH-1:0];
      carry_out <= step_p0[WIDTH];
    end
  end

endmodule
